// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side signal bundle for the shared UART transmitter arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 trmt;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req, req_data, req_last, tx_done,
    input  req_ack, grant, trmt, tx_data, busy, timeout_err
  );

  modport slave (
    input  req, req_data, req_last, tx_done,
    output req_ack, grant, trmt, tx_data, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART transmitter between NUM_REQ
// byte-stream requesters, with forced release on MAX_PKT bytes or tx_done timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int MAX_PKT    = 64,
  parameter int TX_TIMEOUT = 200000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int TW = $clog2(TX_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t             r_state, w_state_next;
  logic [NUM_REQ-1:0] r_rr, w_rr_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_req_ack, w_req_ack_next;
  logic               r_trmt, w_trmt_next;
  logic [7:0]         r_tx_data, w_tx_data_next;
  logic               r_busy, w_busy_next;
  logic               r_timeout_err, w_timeout_err_next;
  logic [CW-1:0]      r_byte_cnt, w_byte_cnt_next;
  logic [TW-1:0]      r_timer, w_timer_next;
  logic               r_last, w_last_next;

  logic [NUM_REQ-1:0] w_hi, w_pick, w_rot;
  logic               w_g_req, w_g_last;
  logic [7:0]         w_g_data;
  logic [7:0][NUM_REQ-1:0] w_col;

  // The round-robin pointer is kept one-hot: requests at or above it are
  // preferred, otherwise the lowest request wins (wrap-around).
  assign w_hi   = bus.req & ~(r_rr - NUM_REQ'(1));
  assign w_pick = (|w_hi) ? (w_hi & (~w_hi + NUM_REQ'(1)))
                          : (bus.req & (~bus.req + NUM_REQ'(1)));
  assign w_rot  = (r_grant << 1) | (r_grant >> (NUM_REQ - 1));

  assign w_g_req  = |(bus.req & r_grant);
  assign w_g_last = |(bus.req_last & r_grant);

  // Grant is one-hot, so the owner's byte is an AND-OR mux per bit column.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    for (genvar gb = 0; gb < 8; gb++) begin : g_bit
      assign w_col[gb][gi] = bus.req_data[8*gi+gb] & r_grant[gi];
    end
  end
  for (genvar gi = 0; gi < 8; gi++) begin : g_data
    assign w_g_data[gi] = |w_col[gi];
  end

  always_comb begin
    w_state_next       = r_state;
    w_rr_next          = r_rr;
    w_grant_next       = r_grant;
    w_req_ack_next     = '0;
    w_trmt_next        = 1'b0;
    w_tx_data_next     = r_tx_data;
    w_timeout_err_next = 1'b0;
    w_byte_cnt_next    = r_byte_cnt;
    w_timer_next       = r_timer;
    w_last_next        = r_last;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_grant_next    = w_pick;
          w_byte_cnt_next = '0;
          w_state_next    = LOAD;
        end
      end
      LOAD: begin
        if (w_g_req) begin
          w_tx_data_next  = w_g_data;
          w_trmt_next     = 1'b1;
          w_req_ack_next  = r_grant;
          w_last_next     = w_g_last | (r_byte_cnt == CW'(MAX_PKT - 1));
          w_byte_cnt_next = r_byte_cnt + CW'(1);
          w_timer_next    = '0;
          w_state_next    = SEND;
        end
      end
      SEND: begin
        w_timer_next = r_timer + TW'(1);
        if (bus.tx_done) begin
          if (r_last) begin
            w_grant_next = '0;
            w_rr_next    = w_rot;
            w_state_next = IDLE;
          end else begin
            w_state_next = LOAD;
          end
        end else if (r_timer == TW'(TX_TIMEOUT - 1)) begin
          w_timeout_err_next = 1'b1;
          w_grant_next       = '0;
          w_rr_next          = w_rot;
          w_state_next       = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    w_busy_next = (w_state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rr          <= NUM_REQ'(1);
      r_grant       <= '0;
      r_req_ack     <= '0;
      r_trmt        <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_byte_cnt    <= '0;
      r_timer       <= '0;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rr          <= w_rr_next;
      r_grant       <= w_grant_next;
      r_req_ack     <= w_req_ack_next;
      r_trmt        <= w_trmt_next;
      r_tx_data     <= w_tx_data_next;
      r_busy        <= w_busy_next;
      r_timeout_err <= w_timeout_err_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_timer       <= w_timer_next;
      r_last        <= w_last_next;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.req_ack     = r_req_ack;
  assign bus.trmt        = r_trmt;
  assign bus.tx_data     = r_tx_data;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed table and sequences plus random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int MP = 4;
  localparam int TO = 50;
  localparam int DW = 8 * N;
  localparam int OW = 2 * N + 11;

  typedef logic [DW-1:0] dvec_t;
  typedef logic [OW-1:0] ovec_t;

  typedef struct {
    logic [N-1:0] req;
    dvec_t        data;
    logic [N-1:0] last;
    logic         done;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         trmt;
    logic [7:0]   txd;
    logic         busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_PKT(MP), .TX_TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the transmitter, whether it can take a byte,
  // bytes sent in this grant, and cycles spent waiting for tx_done.
  int         m_owner, m_rr, m_sent, m_wait;
  bit         m_ready, m_final;
  logic [N-1:0] m_ack;
  logic       m_trmt, m_err;
  logic [7:0] m_data;

  function automatic bit has(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic ovec_t act_vec();
    return {bus.grant, bus.req_ack, bus.trmt, bus.tx_data, bus.busy, bus.timeout_err};
  endfunction

  function automatic ovec_t exp_vec();
    logic [N-1:0] g;
    g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    return {g, m_ack, m_trmt, m_data, (m_owner >= 0), m_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input ovec_t act, input ovec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {grant,ack,trmt,data,busy,err}=%b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_sent = 0; m_wait = 0;
    m_ready = 0; m_final = 0;
    m_ack = '0; m_trmt = 0; m_err = 0; m_data = '0;
  endtask

  task automatic release_grant();
    m_rr    = (m_owner + 1) % N;
    m_owner = -1;
  endtask

  task automatic model_step(input logic [N-1:0] req, input dvec_t data,
                            input logic [N-1:0] last, input logic done);
    m_trmt = 0; m_ack = '0; m_err = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && has(req, (m_rr + k) % N)) m_owner = (m_rr + k) % N;
      end
      if (m_owner >= 0) begin m_ready = 1; m_sent = 0; end
    end else if (m_ready) begin
      if (has(req, m_owner)) begin
        m_trmt  = 1;
        m_ack   = N'(1) << m_owner;
        m_data  = 8'(data >> (8 * m_owner));
        m_sent++;
        m_final = has(last, m_owner) || (m_sent == MP);
        m_ready = 0;
        m_wait  = 0;
      end
    end else if (done) begin
      if (m_final) release_grant();
      else m_ready = 1;
    end else if (m_wait == TO - 1) begin
      m_err = 1;
      release_grant();
    end else begin
      m_wait++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(bus.req, bus.req_data, bus.req_last, bus.tx_done);
    check_vec("cycle", act_vec(), exp_vec());
    if (bus.trmt) $display("tx byte %02h grant %b at %0t", bus.tx_data, bus.grant, $time);
  endtask

  task automatic do_reset();
    bus.req = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_done = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_vec("reset", act_vec(), exp_vec());
  endtask

  task automatic wait_trmt(input string name, input int budget);
    int n;
    n = 0;
    tick();
    while (!bus.trmt && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!bus.trmt) begin
      errors++;
      $display("FAIL %s: trmt not seen within %0d cycles", name, budget);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] req, input dvec_t data, input logic [N-1:0] last,
                              input logic done, input logic [N-1:0] grant, input logic [N-1:0] ack,
                              input logic trmt, input logic [7:0] txd, input logic busy);
    vec_t v;
    v.req = req; v.data = data; v.last = last; v.done = done;
    v.grant = grant; v.ack = ack; v.trmt = trmt; v.txd = txd; v.busy = busy;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [23:0] t1_bytes;
    int          n0, dly, any_bad;
    bit          seen1;

    // Contention: r0 and r1 both request from IDLE with rr at 0; each sends
    // a two-byte packet, stray tx_done pulses in IDLE/LOAD must be ignored.
    tbl.push_back(mk(3'b011, 24'h002010, 3'b000, 1, 3'b001, 3'b000, 0, 8'h00, 1));
    tbl.push_back(mk(3'b011, 24'h002010, 3'b000, 0, 3'b001, 3'b001, 1, 8'h10, 1));
    tbl.push_back(mk(3'b011, 24'h002011, 3'b001, 0, 3'b001, 3'b000, 0, 8'h10, 1));
    tbl.push_back(mk(3'b011, 24'h002011, 3'b001, 1, 3'b001, 3'b000, 0, 8'h10, 1));
    tbl.push_back(mk(3'b011, 24'h002011, 3'b001, 1, 3'b001, 3'b001, 1, 8'h11, 1));
    tbl.push_back(mk(3'b010, 24'h002000, 3'b000, 0, 3'b001, 3'b000, 0, 8'h11, 1));
    tbl.push_back(mk(3'b010, 24'h002000, 3'b000, 1, 3'b000, 3'b000, 0, 8'h11, 0));
    tbl.push_back(mk(3'b010, 24'h002000, 3'b000, 0, 3'b010, 3'b000, 0, 8'h11, 1));
    tbl.push_back(mk(3'b010, 24'h002000, 3'b000, 0, 3'b010, 3'b010, 1, 8'h20, 1));
    tbl.push_back(mk(3'b010, 24'h002100, 3'b010, 0, 3'b010, 3'b000, 0, 8'h20, 1));
    tbl.push_back(mk(3'b010, 24'h002100, 3'b010, 1, 3'b010, 3'b000, 0, 8'h20, 1));
    tbl.push_back(mk(3'b010, 24'h002100, 3'b010, 0, 3'b010, 3'b010, 1, 8'h21, 1));
    tbl.push_back(mk(3'b011, 24'h004030, 3'b000, 0, 3'b010, 3'b000, 0, 8'h21, 1));
    tbl.push_back(mk(3'b011, 24'h004030, 3'b000, 1, 3'b000, 3'b000, 0, 8'h21, 0));
    tbl.push_back(mk(3'b011, 24'h004030, 3'b000, 0, 3'b001, 3'b000, 0, 8'h21, 1));
    tbl.push_back(mk(3'b011, 24'h004030, 3'b000, 0, 3'b001, 3'b001, 1, 8'h30, 1));
    tbl.push_back(mk(3'b011, 24'h004030, 3'b000, 0, 3'b001, 3'b000, 0, 8'h30, 1));

    // Single requester, three-byte packet, tx_done 10 cycles after each trmt
    do_reset();
    t1_bytes = 24'hC3B2A1;
    bus.req = 3'b001;
    bus.req_data = dvec_t'(t1_bytes[7:0]);
    for (int b = 0; b < 3; b++) begin
      wait_trmt("t1_trmt", 10);
      check("t1_data", 32'(bus.tx_data), 32'(8'(t1_bytes >> (8 * b))));
      check("t1_ack", 32'(bus.req_ack), 32'(3'b001));
      if (b < 2) begin
        bus.req_data = dvec_t'(8'(t1_bytes >> (8 * (b + 1))));
        bus.req_last = (b == 1) ? 3'b001 : 3'b000;
      end else begin
        bus.req = '0;
        bus.req_last = '0;
      end
      repeat (9) tick();
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
    check("t1_grant_free", 32'(bus.grant), 32'(0));
    check("t1_busy_free", 32'(bus.busy), 32'(0));

    // Table-driven contention sequence
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      bus.req = tbl[i].req; bus.req_data = tbl[i].data;
      bus.req_last = tbl[i].last; bus.tx_done = tbl[i].done;
      tick();
      check_vec("tbl", act_vec(),
                {tbl[i].grant, tbl[i].ack, tbl[i].trmt, tbl[i].txd, tbl[i].busy, 1'b0});
    end
    bus.tx_done = 1'b0;

    // Forced release after MAX_PKT bytes with r1 pending
    do_reset();
    bus.req = 3'b011;
    bus.req_data = 24'h005560;
    bus.req_last = 3'b010;
    n0 = 0; seen1 = 0;
    for (int c = 0; c < 80 && !seen1; c++) begin
      tick();
      bus.tx_done = 1'b0;
      if (bus.grant == 3'b010) begin
        seen1 = 1;
        check("t3_r0_bytes_before_switch", 32'(n0), 32'(MP));
      end
      if (bus.trmt) begin
        if (bus.grant == 3'b001) n0++;
        bus.req_data[7:0] = 8'(8'h60 + n0);
        bus.tx_done = 1'b1;
      end
    end
    check("t3_switched", 32'(seen1), 32'(1));

    // Timeout: tx_done never returns
    do_reset();
    bus.req = 3'b001; bus.req_data = 24'h000077; bus.req_last = 3'b001;
    wait_trmt("t4_trmt", 5);
    bus.req = '0;
    any_bad = 0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (bus.timeout_err) any_bad++;
    end
    check("t4_early_err", 32'(any_bad), 32'(0));
    tick();
    check("t4_err_pulse", 32'(bus.timeout_err), 32'(1));
    check("t4_grant_drop", 32'(bus.grant), 32'(0));
    tick();
    check("t4_busy_after", 32'(bus.busy), 32'(0));
    check("t4_err_single", 32'(bus.timeout_err), 32'(0));

    // Stall: owner drops req between bytes; r1 waits and must not be acked
    do_reset();
    bus.req = 3'b011; bus.req_data = 24'h009181; bus.req_last = 3'b010;
    wait_trmt("t5_trmt1", 5);
    check("t5_first_owner", 32'(bus.grant), 32'(3'b001));
    bus.req = 3'b010;
    repeat (2) tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    any_bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.trmt || bus.grant != 3'b001 || bus.req_ack != '0) any_bad++;
    end
    check("t5_stall_hold", 32'(any_bad), 32'(0));
    bus.req = 3'b011; bus.req_data = 24'h009182; bus.req_last = 3'b011;
    tick();
    check("t5_resume_trmt", 32'(bus.trmt), 32'(1));
    check("t5_resume_data", 32'(bus.tx_data), 32'(8'h82));
    check("t5_resume_ack", 32'(bus.req_ack), 32'(3'b001));

    // Async reset during SEND; a late tx_done must not trigger anything
    do_reset();
    bus.req = 3'b001; bus.req_data = 24'h0000E5; bus.req_last = 3'b001;
    wait_trmt("t6_trmt", 5);
    bus.req = '0;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check_vec("t6_async_clear", act_vec(), '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    any_bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.trmt || bus.req_ack != '0 || bus.grant != '0) any_bad++;
    end
    check("t6_late_done_ignored", 32'(any_bad), 32'(0));

    // Random traffic against the reference model
    do_reset();
    dly = -1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      bus.tx_done = 1'b0;
      if (bus.trmt) begin
        dly = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(1, 12));
      end else if (dly > 0) begin
        dly--;
      end
      if (dly == 0) begin
        bus.tx_done = 1'b1;
        dly = -1;
      end
      if ($urandom_range(0, 29) == 0) bus.tx_done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (has(bus.req_ack, i) || !has(bus.req, i)) begin
          if ((has(bus.req_ack, i) && $urandom_range(0, 9) < 7) ||
              (!has(bus.req_ack, i) && $urandom_range(0, 9) == 0)) begin
            bus.req = bus.req | (N'(1) << i);
            bus.req_data = (bus.req_data & ~(dvec_t'(8'hFF) << (8 * i))) |
                           (dvec_t'(8'($urandom)) << (8 * i));
            if ($urandom_range(0, 3) == 0) bus.req_last = bus.req_last | (N'(1) << i);
            else bus.req_last = bus.req_last & ~(N'(1) << i);
          end else begin
            bus.req = bus.req & ~(N'(1) << i);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
